shift_right_seq: RTL and testbench

//  Multi-cycle right shifter/rotator for the ALU; complements the combinational left shifter.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/shift_right_step.sv | 39 +++
 rtl/shift_right_seq.sv | 131 +++++++++++++
 tb/tb_shift_right_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op codes, FSM state codes and fill modes for the
//                right shifter.  SHIFT_RIGHT_ROTATE_EN enables op=10 as ROR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [1:0] OP_SHR  = 2'b00;
    localparam logic [1:0] OP_SHRA = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_SIGN = 2'd1,
        FILL_WRAP = 2'd2
    } fill_e;

    // Reserved op=11 (and ROR when rotate is not built) fall back to zero fill.
    function automatic fill_e fill_for_op(input logic [1:0] op);
        fill_e mode;
        mode = FILL_ZERO;
        if (op == OP_SHRA) begin
            mode = FILL_SIGN;
        end
`ifdef SHIFT_RIGHT_ROTATE_EN
        if (op == OP_ROR) begin
            mode = FILL_WRAP;
        end
`endif
        return mode;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right_step.sv
// ============================================================================
//  Module      : shift_right_step
//  Description : Combinational right shift by k bits with zero/sign/wrap fill.
//                Wrap fill exists only when SHIFT_RIGHT_ROTATE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right_step
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KW     = 1
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [KW-1:0]     i_k,
    input  fill_e             i_fill,
    input  logic              i_sign,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_fill_word;

    always_comb begin
        case (i_fill)
            FILL_SIGN: w_fill_word = {DATA_W{i_sign}};
`ifdef SHIFT_RIGHT_ROTATE_EN
            FILL_WRAP: w_fill_word = i_data;
`endif
            default:   w_fill_word = '0;
        endcase
    end

    // The upper word supplies the bits that enter from the MSB side.
    assign o_data = DATA_W'({w_fill_word, i_data} >> i_k);

endmodule

`default_nettype wire

// File: rtl/shift_right_seq.sv
// ============================================================================
//  Module      : shift_right_seq
//  Description : Multi-cycle right shifter/rotator, STEP bits per clock, with
//                start/busy/done handshake.  SHIFT_RIGHT_ROTATE_EN adds ROR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int LW = $clog2(DATA_W);
    localparam int CW = LW + 1;
    localparam int KW = $clog2(STEP) + 1;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CW-1:0]     rem_q, rem_d;
    fill_e             mode_q, mode_d;
    logic              sign_q, sign_d;

    fill_e             w_mode;
    logic [CW-1:0]     w_n;
    logic [KW-1:0]     w_k;
    logic [CW-1:0]     w_rem_next;
    logic [DATA_W-1:0] w_step_out;

    always_comb begin
        w_mode = fill_for_op(op);
        // Any set bit at or above LW means B >= DATA_W: saturate.
        w_n = (|B[DATA_W-1:LW]) ? CW'(DATA_W) : {1'b0, B[LW-1:0]};
`ifdef SHIFT_RIGHT_ROTATE_EN
        if (w_mode == FILL_WRAP) begin
            w_n = {1'b0, B[LW-1:0]};
        end
`endif
    end

    assign w_k        = (rem_q > CW'(STEP)) ? KW'(STEP) : rem_q[KW-1:0];
    assign w_rem_next = rem_q - CW'(w_k);

    shift_right_step #(
        .DATA_W (DATA_W),
        .KW     (KW)
    ) u_step (
        .i_data (data_q),
        .i_k    (w_k),
        .i_fill (mode_q),
        .i_sign (sign_q),
        .o_data (w_step_out)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        result_d = result_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d = A;
                    sign_d = A[DATA_W-1];
                    mode_d = w_mode;
                    rem_d  = w_n;
                    if (w_n == '0) begin
                        state_d  = ST_DONE;
                        result_d = A;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = w_step_out;
                rem_d  = w_rem_next;
                if (w_rem_next == '0) begin
                    state_d  = ST_DONE;
                    result_d = w_step_out;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            mode_q   <= FILL_ZERO;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            sign_q   <= sign_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// ============================================================================
//  Module      : tb_shift_right_seq
//  Description : Scoreboard bench for shift_right_seq, STEP=1 and STEP=4
//                instances side by side; rotate expectations follow
//                SHIFT_RIGHT_ROTATE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_right_seq;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start_r  [2];
    logic [1:0]  op_r     [2];
    logic [31:0] a_r      [2];
    logic [31:0] b_r      [2];
    logic        busy_w   [2];
    logic        done_w   [2];
    logic [31:0] result_w [2];

    logic [31:0] cyc = '0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    shift_right_seq #(.DATA_W(32), .STEP(1)) u_dut_s1 (
        .clock  (clock),
        .clear  (clear),
        .start  (start_r[0]),
        .op     (op_r[0]),
        .A      (a_r[0]),
        .B      (b_r[0]),
        .busy   (busy_w[0]),
        .done   (done_w[0]),
        .result (result_w[0])
    );

    shift_right_seq #(.DATA_W(32), .STEP(4)) u_dut_s4 (
        .clock  (clock),
        .clear  (clear),
        .start  (start_r[1]),
        .op     (op_r[1]),
        .A      (a_r[1]),
        .B      (b_r[1]),
        .busy   (busy_w[1]),
        .done   (done_w[1]),
        .result (result_w[1])
    );

    task automatic compare(input int i, input exp_t e);
        checks++;
        if (result_w[i] !== e.res) begin
            errors++;
            $display("FAIL result inst%0d: got %08h, expected %08h", i, result_w[i], e.res);
        end
        checks++;
        if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL latency inst%0d: done at cycle %0d, expected %0d", i, cyc, e.cyc);
        end
        checks++;
        if (busy_w[i] !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_done inst%0d: got %b, expected 1", i, busy_w[i]);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done_w[0] === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done inst0: result %08h, expected no done", result_w[0]);
            end else begin
                compare(0, q0.pop_front());
            end
        end
        if (done_w[1] === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done inst1: result %08h, expected no done", result_w[1]);
            end else begin
                compare(1, q1.pop_front());
            end
        end
    end

    task automatic push(input int i, input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.cyc = cyc + 32'(lat);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_idle(input int i);
        for (int t = 0; t < 200 && busy_w[i] !== 1'b0; t++) @(negedge clock);
        if (busy_w[i] !== 1'b0) begin
            checks++; errors++;
            $display("FAIL idle_timeout inst%0d: busy %b, expected 0", i, busy_w[i]);
        end
    endtask

    // lat counts edges from the accept edge inclusive up to the edge raising done.
    task automatic issue(input int i, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input int lat, input bit track);
        wait_idle(i);
        start_r[i] = 1'b1;
        op_r[i]    = o;
        a_r[i]     = a;
        b_r[i]     = b;
        if (track) push(i, res, lat);
        @(negedge clock);
        start_r[i] = 1'b0;
        a_r[i]     = ~a;
        b_r[i]     = 32'd0;
        op_r[i]    = ~o;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge clock);
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending %0d/%0d, expected 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic check_outputs(input string name, input int i, input logic b,
                                 input logic d, input logic [31:0] r);
        checks++;
        if (busy_w[i] !== b || done_w[i] !== d || result_w[i] !== r) begin
            errors++;
            $display("FAIL %s inst%0d: busy/done/result %b/%b/%08h, expected %b/%b/%08h",
                     name, i, busy_w[i], done_w[i], result_w[i], b, d, r);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            op_r[i]    = 2'b00;
            a_r[i]     = '0;
            b_r[i]     = '0;
        end
        #1 clear = 1'b1;
        #1;
        check_outputs("reset", 0, 1'b0, 1'b0, 32'h0);
        check_outputs("reset", 1, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // STEP=1 instance
        issue(0, 2'b00, 32'h8000_0000, 32'd4,  32'h0800_0000, 5,  1);
        issue(0, 2'b01, 32'hF000_0000, 32'd40, 32'hFFFF_FFFF, 33, 1);
        issue(0, 2'b00, 32'hF000_0000, 32'd40, 32'h0000_0000, 33, 1);
`ifdef SHIFT_RIGHT_ROTATE_EN
        issue(0, 2'b10, 32'h0000_0001, 32'd33, 32'h8000_0000, 2,  1);
        issue(0, 2'b10, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1,  1);
`else
        issue(0, 2'b10, 32'h0000_0001, 32'd33, 32'h0000_0000, 33, 1);
        issue(0, 2'b10, 32'hDEAD_BEEF, 32'd32, 32'h0000_0000, 33, 1);
`endif
        for (int o = 0; o < 4; o++)
            issue(0, 2'(o), 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1);
        issue(0, 2'b01, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 1);
        issue(0, 2'b01, 32'h7000_0000, 32'd4,  32'h0700_0000, 5,  1);
        issue(0, 2'b11, 32'h8000_0000, 32'd4,  32'h0800_0000, 5,  1);
        issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 1);
        issue(0, 2'b00, 32'h0000_0100, 32'h0000_0021, 32'h0, 33, 1);

        // STEP=4 instance, with a start pulse during SHIFT that must be ignored
        issue(1, 2'b00, 32'hFFFF_0000, 32'd7, 32'h01FF_FE00, 3, 1);
        start_r[1] = 1'b1;
        a_r[1]     = 32'hAAAA_AAAA;
        b_r[1]     = 32'd0;
        @(negedge clock);
        start_r[1] = 1'b0;
        issue(1, 2'b01, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 9, 1);
`ifdef SHIFT_RIGHT_ROTATE_EN
        issue(1, 2'b10, 32'h1234_5678, 32'd36, 32'h8123_4567, 2, 1);
        issue(1, 2'b10, 32'h1234_5678, 32'd8,  32'h7812_3456, 3, 1);
`else
        issue(1, 2'b10, 32'h1234_5678, 32'd36, 32'h0000_0000, 9, 1);
        issue(1, 2'b10, 32'h1234_5678, 32'd8,  32'h0012_3456, 3, 1);
`endif
        issue(1, 2'b00, 32'h0000_0003, 32'd1,  32'h0000_0001, 2, 1);
        issue(1, 2'b00, 32'h8765_4321, 32'd32, 32'h0000_0000, 9, 1);

        // start held high: re-accepted on the IDLE cycle after each DONE
        drain();
        wait_idle(0);
        push(0, 32'h1234_5678, 1);
        push(0, 32'h1234_5678, 3);
        push(0, 32'h1234_5678, 5);
        start_r[0] = 1'b1;
        op_r[0]    = 2'b00;
        a_r[0]     = 32'h1234_5678;
        b_r[0]     = 32'd0;
        repeat (5) @(negedge clock);
        start_r[0] = 1'b0;
        drain();

        // clear mid-operation: abandoned, no done, outputs zero immediately
        issue(0, 2'b00, 32'hFFFF_FFFF, 32'd20, 32'h0, 21, 0);
        repeat (3) @(negedge clock);
        check_outputs("busy_mid_shift", 0, 1'b1, 1'b0, 32'h1234_5678);
        #2 clear = 1'b1;
        #1;
        check_outputs("clear_mid_shift", 0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        issue(0, 2'b01, 32'h8000_0000, 32'd2, 32'hE000_0000, 3, 1);
        drain();
        repeat (30) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
